// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types and helpers for the sorted-array priority queue
//
// Purpose: operation encoding, default-width cell type and the wrap-around
// (serial-number) timestamp compare used by pq_sorted_array.
// Ports: none (package).
package pq_pkg;

   // Operation code, fixed at 3 bits. Codes 3'd5..3'd7 are reserved and are
   // treated by the queue as NOP with err_o raised.
   typedef enum logic [2:0] {
      OP_PUSH    = 3'd0,
      OP_POP     = 3'd1,
      OP_NOP     = 3'd2,
      OP_DROP    = 3'd3,
      OP_REPLACE = 3'd4
   } op_t;

   localparam int DEF_TIME_WIDTH = 16;
   localparam int DEF_ID_WIDTH   = 16;
   localparam int MAX_KEY_WIDTH  = 64;

   // Storage cell at the default widths; the queue declares its own packed
   // cell from its parameters with the same field order.
   typedef struct packed {
      logic                      valid;
      logic [DEF_TIME_WIDTH-1:0] tkey;
      logic [DEF_ID_WIDTH-1:0]   id;
   } cell_t;

   // a is before b when bit (width-1) of (a - b) is set. Operands are passed
   // zero-extended to MAX_KEY_WIDTH; the subtraction is exact modulo
   // 2^width in the low bits, so one generic function serves any width.
   function automatic logic time_before(input logic [MAX_KEY_WIDTH-1:0] a,
                                        input logic [MAX_KEY_WIDTH-1:0] b,
                                        input int                       width);
      logic [MAX_KEY_WIDTH-1:0] diff;
      logic [MAX_KEY_WIDTH-1:0] sh;
      diff = a - b;
      sh   = diff >> (width - 1);
      return sh[0];
   endfunction

endpackage

// File: rtl/pq_cell.sv
// rtl/pq_cell.sv - one storage slot of the sorted-array priority queue
//
// Purpose: holds one packed {valid, time, id} entry. Each cycle it keeps its
// value, loads the new entry, takes its lower neighbour (insert shifts the
// tail up) or takes its upper neighbour (removal shifts entries down).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          take new_i
//   shift_up_i      take lower_i (entry from index-1)
//   shift_down_i    take upper_i (entry from index+1)
//   new_i           entry being inserted
//   lower_i/upper_i neighbouring slot contents
//   q_o             current slot contents
module pq_cell #(
   parameter int W = 33
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         shift_up_i,
   input  logic         shift_down_i,
   input  logic [W-1:0] new_i,
   input  logic [W-1:0] lower_i,
   input  logic [W-1:0] upper_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;
   logic [W-1:0] slot_d;

   // Controls are mutually exclusive from the top level; the priority order
   // only makes the mux unambiguous.
   always_comb begin
      slot_d = slot_q;
      if (load_i) begin
         slot_d = new_i;
      end else if (shift_up_i) begin
         slot_d = lower_i;
      end else if (shift_down_i) begin
         slot_d = upper_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/pq_sorted_array.sv
// rtl/pq_sorted_array.sv - register-based sorted priority queue (earliest deadline at head)
//
// Purpose: keeps DEPTH entries ordered by wrap-around timestamp, valid
// entries packed at low indices, head at index 0. Supports PUSH, POP, NOP,
// DROP (by id) and REPLACE (pop head + push in one cycle), with an optional
// evict-latest policy when full.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   op_valid_i, op_i               op strobe and pq_pkg::op_t code
//   time_i, id_i                   key / id for PUSH, REPLACE, DROP
//   pop_valid_o, pop_time_o/id_o   registered pop result (pulse)
//   evict_valid_o, evict_id_o      registered tail-eviction report (pulse)
//   err_o                          registered illegal-op pulse
//   head_time_o, head_id_o         combinational head entry
//   count_o, full_o, empty_o       occupancy
module pq_sorted_array
   import pq_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int TIME_WIDTH    = 16,
   parameter int ID_WIDTH      = 16,
   parameter int EVICT_ON_FULL = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       op_valid_i,
   input  logic [2:0]                 op_i,
   input  logic [TIME_WIDTH-1:0]      time_i,
   input  logic [ID_WIDTH-1:0]        id_i,
   output logic                       pop_valid_o,
   output logic [TIME_WIDTH-1:0]      pop_time_o,
   output logic [ID_WIDTH-1:0]        pop_id_o,
   output logic                       evict_valid_o,
   output logic [ID_WIDTH-1:0]        evict_id_o,
   output logic                       err_o,
   output logic [TIME_WIDTH-1:0]      head_time_o,
   output logic [ID_WIDTH-1:0]        head_id_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int W  = 1 + TIME_WIDTH + ID_WIDTH;

   typedef struct packed {
      logic                  valid;
      logic [TIME_WIDTH-1:0] tkey;
      logic [ID_WIDTH-1:0]   id;
   } slot_t;

   logic [W-1:0] cell_q [DEPTH];
   logic [W-1:0] nbr_lo [DEPTH];
   logic [W-1:0] nbr_hi [DEPTH];
   slot_t        ent    [DEPTH];
   logic [W-1:0] new_ent;

   logic [DEPTH-1:0] le;      // entry is before-or-equal the incoming key
   logic [DEPTH-1:0] match;   // entry id equals id_i
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] up;
   logic [DEPTH-1:0] down;

   logic [CW-1:0] ins_pos;
   logic [CW-1:0] repl_pos;
   logic [CW-1:0] drop_pos;
   logic          drop_hit;

   logic m_ins, m_pop, m_repl, m_drop;
   logic err_d, evict_d;
   logic full, empty;
   logic new_before_tail;

   logic [CW-1:0]         count_q, count_d;
   logic                  pop_valid_q;
   logic [TIME_WIDTH-1:0] pop_time_q;
   logic [ID_WIDTH-1:0]   pop_id_q;
   logic                  evict_valid_q;
   logic [ID_WIDTH-1:0]   evict_id_q;
   logic                  err_q;

   assign new_ent = {1'b1, time_i, id_i};

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_slot
         if (g == 0) begin : g_lo0
            assign nbr_lo[g] = '0;
         end else begin : g_lo
            assign nbr_lo[g] = cell_q[g-1];
         end
         if (g == DEPTH - 1) begin : g_hi_top
            assign nbr_hi[g] = '0;
         end else begin : g_hi
            assign nbr_hi[g] = cell_q[g+1];
         end

         assign ent[g] = cell_q[g];

         // FIFO among equals: an equal key counts as "before-or-equal", so
         // the new entry lands after every existing equal key.
         assign le[g]    = ent[g].valid &&
                           !time_before(MAX_KEY_WIDTH'(time_i),
                                        MAX_KEY_WIDTH'(ent[g].tkey), TIME_WIDTH);
         assign match[g] = ent[g].valid && (ent[g].id == id_i);

         pq_cell #(.W(W)) u_cell (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .load_i      (load[g]),
            .shift_up_i  (up[g]),
            .shift_down_i(down[g]),
            .new_i       (new_ent),
            .lower_i     (nbr_lo[g]),
            .upper_i     (nbr_hi[g]),
            .q_o         (cell_q[g])
         );
      end
   endgenerate

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign new_before_tail = time_before(MAX_KEY_WIDTH'(time_i),
                                        MAX_KEY_WIDTH'(ent[DEPTH-1].tkey), TIME_WIDTH);

   // le is a prefix over the sorted array, so the insert point is the first
   // slot that is not before-or-equal the new key (or DEPTH if none).
   always_comb begin
      ins_pos  = CW'(DEPTH);
      drop_pos = CW'(DEPTH);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!le[i]) begin
            ins_pos = CW'(i);
         end
         if (match[i]) begin
            drop_pos = CW'(i);
         end
      end
      drop_hit = |match;
      // For REPLACE the head leaves first; the insert point in the shifted
      // array is one lower, unless the new key already beats the head.
      repl_pos = (ins_pos == '0) ? '0 : ins_pos - CW'(1);
   end

   always_comb begin
      m_ins   = 1'b0;
      m_pop   = 1'b0;
      m_repl  = 1'b0;
      m_drop  = 1'b0;
      err_d   = 1'b0;
      evict_d = 1'b0;
      count_d = count_q;
      if (op_valid_i) begin
         case (op_i)
            OP_PUSH: begin
               if (!full) begin
                  m_ins   = 1'b1;
                  count_d = count_q + CW'(1);
               end else if ((EVICT_ON_FULL != 0) && new_before_tail) begin
                  // Tail falls off the top when everything shifts up.
                  m_ins   = 1'b1;
                  evict_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_POP: begin
               if (!empty) begin
                  m_pop   = 1'b1;
                  count_d = count_q - CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_REPLACE: begin
               if (!empty) begin
                  m_repl = 1'b1;
               end else begin
                  m_ins   = 1'b1;
                  err_d   = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            OP_DROP: begin
               if (drop_hit) begin
                  m_drop  = 1'b1;
                  count_d = count_q - CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_NOP: begin
            end
            default: begin
               err_d = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         load[i] = 1'b0;
         up[i]   = 1'b0;
         down[i] = 1'b0;
         if (m_ins) begin
            load[i] = (i == int'(ins_pos));
            up[i]   = (i >  int'(ins_pos));
         end else if (m_pop) begin
            down[i] = 1'b1;
         end else if (m_repl) begin
            load[i] = (i == int'(repl_pos));
            down[i] = (i <  int'(repl_pos));
         end else if (m_drop) begin
            down[i] = (i >= int'(drop_pos));
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q       <= '0;
         pop_valid_q   <= 1'b0;
         pop_time_q    <= '0;
         pop_id_q      <= '0;
         evict_valid_q <= 1'b0;
         evict_id_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         count_q       <= count_d;
         pop_valid_q   <= m_pop | m_repl;
         evict_valid_q <= evict_d;
         err_q         <= err_d;
         if (m_pop | m_repl) begin
            pop_time_q <= ent[0].tkey;
            pop_id_q   <= ent[0].id;
         end
         if (evict_d) begin
            evict_id_q <= ent[DEPTH-1].id;
         end
      end
   end

   assign pop_valid_o   = pop_valid_q;
   assign pop_time_o    = pop_time_q;
   assign pop_id_o      = pop_id_q;
   assign evict_valid_o = evict_valid_q;
   assign evict_id_o    = evict_id_q;
   assign err_o         = err_q;
   assign head_time_o   = ent[0].tkey;
   assign head_id_o     = ent[0].id;
   assign count_o       = count_q;
   assign full_o        = full;
   assign empty_o       = empty;

endmodule

// File: tb/tb_pq_sorted_array.sv
// tb/tb_pq_sorted_array.sv - self-checking bench for pq_sorted_array
module tb_pq_sorted_array;
   import pq_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op;
   logic [15:0] tkey;
   logic [15:0] id;

   logic        e_pv, e_ev, e_err, e_full, e_empty;
   logic [15:0] e_pt, e_pid, e_eid, e_ht, e_hid;
   logic [3:0]  e_cnt;
   logic        r_pv, r_ev, r_err, r_full, r_empty;
   logic [15:0] r_pt, r_pid, r_eid, r_ht, r_hid;
   logic [3:0]  r_cnt;

   int errors = 0;
   int checks = 0;

   pq_sorted_array #(.DEPTH(8), .TIME_WIDTH(16), .ID_WIDTH(16), .EVICT_ON_FULL(1)) u_evict (
      .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_i(op),
      .time_i(tkey), .id_i(id),
      .pop_valid_o(e_pv), .pop_time_o(e_pt), .pop_id_o(e_pid),
      .evict_valid_o(e_ev), .evict_id_o(e_eid), .err_o(e_err),
      .head_time_o(e_ht), .head_id_o(e_hid), .count_o(e_cnt),
      .full_o(e_full), .empty_o(e_empty)
   );

   pq_sorted_array #(.DEPTH(8), .TIME_WIDTH(16), .ID_WIDTH(16), .EVICT_ON_FULL(0)) u_reject (
      .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_i(op),
      .time_i(tkey), .id_i(id),
      .pop_valid_o(r_pv), .pop_time_o(r_pt), .pop_id_o(r_pid),
      .evict_valid_o(r_ev), .evict_id_o(r_eid), .err_o(r_err),
      .head_time_o(r_ht), .head_id_o(r_hid), .count_o(r_cnt),
      .full_o(r_full), .empty_o(r_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] t;
      logic [15:0] id;
      logic        pv;
      logic [15:0] pt;
      logic [15:0] pid;
      logic        err;
      logic [15:0] head;
      logic [3:0]  cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one op on the falling edge, let it take effect at the rising
   // edge, and return 1 time unit later with outputs settled.
   task automatic apply(input logic [2:0] o, input logic [15:0] t, input logic [15:0] i);
      @(negedge clk);
      op_valid = 1'b1;
      op       = o;
      tkey     = t;
      id       = i;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic check_vec(input string tag, input vec_t v,
                            input logic pv, input logic [15:0] pt, input logic [15:0] pid,
                            input logic err, input logic ev, input logic [15:0] head,
                            input logic [3:0] cnt);
      chk({tag, " pop_valid"}, 32'(pv), 32'(v.pv));
      chk({tag, " err"}, 32'(err), 32'(v.err));
      chk({tag, " evict"}, 32'(ev), 32'd0);
      chk({tag, " count"}, 32'(cnt), 32'(v.cnt));
      if (v.pv) begin
         chk({tag, " pop_time"}, 32'(pt), 32'(v.pt));
         chk({tag, " pop_id"}, 32'(pid), 32'(v.pid));
      end
      if (v.cnt != 0) begin
         chk({tag, " head_time"}, 32'(head), 32'(v.head));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op       = 3'(OP_NOP);
      tkey     = '0;
      id       = '0;

      //            op          time      id     pv  pt       pid  err head     cnt
      tbl.push_back('{3'(OP_PUSH),    16'd30,   16'd1,  0, 16'd0,   16'd0,  0, 16'd30,   4'd1});
      tbl.push_back('{3'(OP_PUSH),    16'd10,   16'd2,  0, 16'd0,   16'd0,  0, 16'd10,   4'd2});
      tbl.push_back('{3'(OP_PUSH),    16'd20,   16'd3,  0, 16'd0,   16'd0,  0, 16'd10,   4'd3});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd10,  16'd2,  0, 16'd20,   4'd2});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd20,  16'd3,  0, 16'd30,   4'd1});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd30,  16'd1,  0, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  0, 16'd0,   16'd0,  1, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_PUSH),    16'hFFF0, 16'd4,  0, 16'd0,   16'd0,  0, 16'hFFF0, 4'd1});
      tbl.push_back('{3'(OP_PUSH),    16'h0010, 16'd5,  0, 16'd0,   16'd0,  0, 16'hFFF0, 4'd2});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'hFFF0,16'd4,  0, 16'h0010, 4'd1});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'h0010,16'd5,  0, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_PUSH),    16'd5,    16'd7,  0, 16'd0,   16'd0,  0, 16'd5,    4'd1});
      tbl.push_back('{3'(OP_PUSH),    16'd5,    16'd8,  0, 16'd0,   16'd0,  0, 16'd5,    4'd2});
      tbl.push_back('{3'(OP_PUSH),    16'd5,    16'd9,  0, 16'd0,   16'd0,  0, 16'd5,    4'd3});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd5,   16'd7,  0, 16'd5,    4'd2});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd5,   16'd8,  0, 16'd5,    4'd1});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd5,   16'd9,  0, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_PUSH),    16'd10,   16'd10, 0, 16'd0,   16'd0,  0, 16'd10,   4'd1});
      tbl.push_back('{3'(OP_PUSH),    16'd20,   16'd11, 0, 16'd0,   16'd0,  0, 16'd10,   4'd2});
      tbl.push_back('{3'(OP_PUSH),    16'd30,   16'd12, 0, 16'd0,   16'd0,  0, 16'd10,   4'd3});
      tbl.push_back('{3'(OP_REPLACE), 16'd15,   16'd13, 1, 16'd10,  16'd10, 0, 16'd15,   4'd3});
      tbl.push_back('{3'(OP_DROP),    16'd0,    16'd11, 0, 16'd0,   16'd0,  0, 16'd15,   4'd2});
      tbl.push_back('{3'(OP_DROP),    16'd0,    16'd99, 0, 16'd0,   16'd0,  1, 16'd15,   4'd2});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd15,  16'd13, 0, 16'd30,   4'd1});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd30,  16'd12, 0, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_REPLACE), 16'd40,   16'd14, 0, 16'd0,   16'd0,  1, 16'd40,   4'd1});
      tbl.push_back('{3'(OP_REPLACE), 16'd35,   16'd15, 1, 16'd40,  16'd14, 0, 16'd35,   4'd1});
      tbl.push_back('{3'(OP_POP),     16'd0,    16'd0,  1, 16'd35,  16'd15, 0, 16'd0,    4'd0});
      tbl.push_back('{3'(OP_NOP),     16'd9,    16'd9,  0, 16'd0,   16'd0,  0, 16'd0,    4'd0});
      tbl.push_back('{3'd7,           16'd9,    16'd9,  0, 16'd0,   16'd0,  1, 16'd0,    4'd0});

      // Reset state
      #12;
      chk("reset count", 32'(e_cnt), 32'd0);
      chk("reset empty", 32'(e_empty), 32'd1);
      chk("reset full", 32'(e_full), 32'd0);
      chk("reset pop_valid", 32'(e_pv), 32'd0);
      chk("reset err", 32'(e_err), 32'd0);
      chk("reset evict", 32'(e_ev), 32'd0);
      chk("reset head_time", 32'(e_ht), 32'd0);
      chk("reset pop_id", 32'(e_pid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         apply(tbl[k].op, tbl[k].t, tbl[k].id);
         check_vec($sformatf("vec%0d evict-dut", k), tbl[k], e_pv, e_pt, e_pid, e_err, e_ev, e_ht, e_cnt);
         check_vec($sformatf("vec%0d reject-dut", k), tbl[k], r_pv, r_pt, r_pid, r_err, r_ev, r_ht, r_cnt);
      end
      chk("empty after table", 32'(e_empty), 32'd1);

      // Fill to DEPTH with keys 100..107, ids 200..207
      for (int k = 0; k < 8; k++) begin
         apply(3'(OP_PUSH), 16'(100 + k), 16'(200 + k));
         chk($sformatf("fill%0d count", k), 32'(e_cnt), 32'(k + 1));
      end
      chk("full flag", 32'(e_full), 32'd1);
      chk("full flag reject", 32'(r_full), 32'd1);

      // Earlier key into a full queue
      apply(3'(OP_PUSH), 16'd50, 16'd250);
      chk("evict pulse", 32'(e_ev), 32'd1);
      chk("evict id", 32'(e_eid), 32'd207);
      chk("evict err", 32'(e_err), 32'd0);
      chk("evict head", 32'(e_ht), 32'd50);
      chk("evict count", 32'(e_cnt), 32'd8);
      chk("reject err", 32'(r_err), 32'd1);
      chk("reject evict", 32'(r_ev), 32'd0);
      chk("reject head", 32'(r_ht), 32'd100);
      chk("reject count", 32'(r_cnt), 32'd8);

      // Later key than the tail into a full queue
      apply(3'(OP_PUSH), 16'd200, 16'd251);
      chk("late push err evict-dut", 32'(e_err), 32'd1);
      chk("late push no evict", 32'(e_ev), 32'd0);
      chk("late push err reject-dut", 32'(r_err), 32'd1);

      // Drain both and confirm contents
      for (int k = 0; k < 8; k++) begin
         apply(3'(OP_POP), 16'd0, 16'd0);
         chk($sformatf("drain%0d evict pop_time", k), 32'(e_pt), (k == 0) ? 32'd50 : 32'(100 + k - 1));
         chk($sformatf("drain%0d evict pop_id", k), 32'(e_pid), (k == 0) ? 32'd250 : 32'(200 + k - 1));
         chk($sformatf("drain%0d reject pop_time", k), 32'(r_pt), 32'(100 + k));
         chk($sformatf("drain%0d reject pop_id", k), 32'(r_pid), 32'(200 + k));
      end
      chk("drained empty", 32'(e_empty), 32'd1);

      // Asynchronous reset mid-sequence
      apply(3'(OP_PUSH), 16'd1, 16'd1);
      apply(3'(OP_PUSH), 16'd2, 16'd2);
      chk("pre-reset count", 32'(e_cnt), 32'd2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset count", 32'(e_cnt), 32'd0);
      chk("async reset empty", 32'(r_empty), 32'd1);
      op_valid = 1'b1;
      op       = 3'(OP_PUSH);
      tkey     = 16'd3;
      id       = 16'd3;
      @(posedge clk);
      #1;
      chk("op under reset ignored", 32'(e_cnt), 32'd0);
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      apply(3'(OP_NOP), 16'd0, 16'd0);
      chk("post-reset count", 32'(e_cnt), 32'd0);
      chk("post-reset err", 32'(e_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pq_sorted_array.md
Name: pq_sorted_array

Overview:
- Parametrised, register-based sorted priority queue for the AnTiQ timer/event scheduler.
- Successor to the fixed 8-deep, 16-bit array queue. Adds parametrisable depth and key/id widths, wrap-around-safe timestamp ordering, a REPLACE op (pop head + push in one cycle), drop-by-id, and a selectable full-queue policy (reject or evict-latest).
- Sits between the event producers and the dispatch logic; the head of the queue is always the earliest deadline.

Parameters:
- DEPTH, 8, number of entries (>=2).
- TIME_WIDTH, 16, key (timestamp) width in bits.
- ID_WIDTH, 16, payload id width in bits.
- EVICT_ON_FULL, 0, 0 = reject PUSH when full; 1 = evict tail when the new key is earlier than the tail key.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- op_valid_i  in  1  op request strobe; one op per cycle, always accepted.
- op_i  in  3  pq_pkg::op_t (PUSH, POP, NOP, DROP, REPLACE).
- time_i  in  TIME_WIDTH  key for PUSH/REPLACE.
- id_i  in  ID_WIDTH  id for PUSH/REPLACE/DROP.
- pop_valid_o  out  1  registered pop result valid (one-cycle pulse).
- pop_time_o  out  TIME_WIDTH  popped key.
- pop_id_o  out  ID_WIDTH  popped id.
- evict_valid_o  out  1  one-cycle pulse: tail entry evicted.
- evict_id_o  out  ID_WIDTH  evicted id.
- err_o  out  1  one-cycle pulse on an illegal op.
- head_time_o  out  TIME_WIDTH  current head key (valid when !empty_o).
- head_id_o  out  ID_WIDTH  current head id.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.

Behaviour:
- Reset (async, rst_ni=0):
  - All entries invalid; count_o=0; empty_o=1; full_o=0.
  - All pulse outputs 0; pop/evict/head data outputs 0.
  - Reset mid-op discards the op and all contents.
- Storage: entries 0..DEPTH-1, ascending by key, valid entries packed at low indices; head = index 0. head_*_o is combinational from entry 0.
- Ordering: "a before b" iff MSB of (a - b) mod 2^TIME_WIDTH is 1 (serial-number compare). Correct only while all live keys lie within 2^(TIME_WIDTH-1) of each other; keys outside that window give undefined order, with no error reported.
- Ties: an equal key is inserted after existing equal keys (FIFO among equals).
- Ops take effect at the clock edge with op_valid_i=1; the new state is visible the next cycle. op_valid_i=0 or NOP: no change.
- PUSH, not full: insert at the first position whose key is not before-or-equal to time_i; shift the tail up by one; count+1.
- PUSH, full, EVICT_ON_FULL=0: no change; err_o=1.
- PUSH, full, EVICT_ON_FULL=1:
  - If time_i is before the tail key: insert, discard the tail, evict_valid_o=1, evict_id_o=old tail id; count unchanged.
  - Otherwise: no change; err_o=1.
- POP, not empty: pop_valid_o=1 next cycle with the old head; shift all entries down; count-1.
- POP, empty: err_o=1; pop_valid_o=0.
- REPLACE, not empty: pop the old head (outputs as POP) and insert the new entry in the same cycle; count unchanged. The new key may land at index 0.
- REPLACE, empty: behaves as PUSH; err_o=1 to flag the missing pop; pop_valid_o=0.
- DROP: remove the lowest-index valid entry with id == id_i; shift the entries above it down; count-1. No match or empty: err_o=1.
- Latency: one cycle for all outputs. Pulses are single-cycle and registered.
- Undefined op_i encodings: treated as NOP with err_o=1.

Decomposition:
- pq_pkg:
  - Extend op_t with REPLACE.
  - Add an encoding note fixing op_t to 3 bits.
  - Add function time_before(a, b) for the serial compare; the block uses TIME_WIDTH as a function argument width, so the function is written generic via a width-sized local.
  - Keep cell_t for the default widths. The module declares its own packed cell struct from its parameters.
- Sub-module pq_cell: one storage slot holding valid/time/id. Inputs are neighbour data plus shift_up/shift_down/load controls derived from per-slot compare flags. The top level generates DEPTH instances and the priority/insert-position logic.

Test Plan:
- Reset, then PUSH keys 30, 10, 20 (ids 1, 2, 3) → head_time_o=10, count_o=3; three POPs give pop ids 2, 3, 1 each one cycle later; then empty_o=1.
- Fill DEPTH=8 with keys 100..107; PUSH 50 with EVICT_ON_FULL=1 → evict_valid_o pulse with the id of 107, head=50, count_o=8. With EVICT_ON_FULL=0 → err_o pulse, contents unchanged.
- Wrap-around: PUSH 0xFFF0 then 0x0010 → head 0xFFF0; POP returns 0xFFF0 then 0x0010.
- Equal keys: PUSH (5, id 7), (5, id 8), (5, id 9) → pops return ids 7, 8, 9.
- Queue holds 10, 20, 30: REPLACE with key 15 → pop_time_o=10, new head 15, count_o=3. REPLACE on an empty queue → err_o=1, count_o=1.
- DROP id of the middle entry → remaining order intact, count-1. DROP a missing id → err_o=1. POP on empty → err_o=1, pop_valid_o=0. Reset asserted mid-sequence → count_o=0 immediately.
